// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline.
// Merges load-use, branch-flush and memory-wait hazards, and keeps hazard counters.
module pipeline_stall_controller #(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ex_memread_i,
  input  logic [4:0]       ex_rd_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_branch_taken_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  input  logic             clr_cnt_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_noop_o,
  output logic             pipe_freeze_o,
  output logic             timeout_err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [CNT_W-1:0] freeze_cnt_o
);

  localparam int WCW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WCW-1:0] LP_WLAST = WCW'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LP_CMAX = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_FAULT
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [WCW-1:0] r_wait_cnt;
  logic [WCW-1:0] w_wait_nxt;
  logic           w_mem_freeze;
  logic           w_load_use;
  logic           w_stall_evt;
  logic           w_flush_evt;

  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic [CNT_W-1:0] r_freeze_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
    end
  end

  // The IDLE cycle that raises the freeze counts as the first waiting cycle.
  always_comb begin
    w_state_nxt  = r_state;
    w_wait_nxt   = r_wait_cnt;
    w_mem_freeze = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (mem_req_i && !mem_ack_i) begin
          w_mem_freeze = 1'b1;
          w_state_nxt  = S_WAIT;
          w_wait_nxt   = WCW'(1);
        end
      end
      S_WAIT: begin
        if (mem_ack_i) begin
          w_state_nxt = S_IDLE;
          w_wait_nxt  = '0;
        end else begin
          w_mem_freeze = 1'b1;
          if (r_wait_cnt == LP_WLAST) begin
            w_state_nxt = S_FAULT;
          end else begin
            w_wait_nxt = r_wait_cnt + WCW'(1);
          end
        end
      end
      S_FAULT: begin
        w_mem_freeze = 1'b1;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_wait_nxt  = '0;
      end
    endcase
  end

  assign w_load_use = ex_memread_i && (ex_rd_i != 5'd0) &&
                      ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));

  always_comb begin
    pc_write_o    = 1'b1;
    ifid_write_o  = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_noop_o   = 1'b0;
    pipe_freeze_o = 1'b0;
    if (rst_i || w_mem_freeze) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      pipe_freeze_o = 1'b1;
    end else if (w_load_use) begin
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
      idex_noop_o  = 1'b1;
    end else if (id_branch_taken_i) begin
      ifid_flush_o = 1'b1;
    end
  end

  assign timeout_err_o = (r_state == S_FAULT);
  assign w_stall_evt   = !w_mem_freeze && w_load_use;
  assign w_flush_evt   = !w_mem_freeze && !w_load_use && id_branch_taken_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stall_cnt  <= '0;
      r_flush_cnt  <= '0;
      r_freeze_cnt <= '0;
    end else if (clr_cnt_i) begin
      r_stall_cnt  <= '0;
      r_flush_cnt  <= '0;
      r_freeze_cnt <= '0;
    end else begin
      if (w_stall_evt && (r_stall_cnt != LP_CMAX)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_flush_evt && (r_flush_cnt != LP_CMAX)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
      if (w_mem_freeze && (r_freeze_cnt != LP_CMAX)) begin
        r_freeze_cnt <= r_freeze_cnt + CNT_W'(1);
      end
    end
  end

  assign stall_cnt_o  = r_stall_cnt;
  assign flush_cnt_o  = r_flush_cnt;
  assign freeze_cnt_o = r_freeze_cnt;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller.
// Runs with TIMEOUT=8 and CNT_W=4 so timeout and saturation are reachable.
module tb_pipeline_stall_controller;

  logic       clk;
  logic       rst;
  logic       memread;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic       br;
  logic       req;
  logic       ack;
  logic       clr;
  logic       pc_w;
  logic       ifid_w;
  logic       flush;
  logic       noop;
  logic       freeze;
  logic       terr;
  logic [3:0] stall_cnt;
  logic [3:0] flush_cnt;
  logic [3:0] freeze_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  pipeline_stall_controller #(.TIMEOUT(8), .CNT_W(4)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .ex_memread_i      (memread),
    .ex_rd_i           (rd),
    .id_rs1_i          (rs1),
    .id_rs2_i          (rs2),
    .id_branch_taken_i (br),
    .mem_req_i         (req),
    .mem_ack_i         (ack),
    .clr_cnt_i         (clr),
    .pc_write_o        (pc_w),
    .ifid_write_o      (ifid_w),
    .ifid_flush_o      (flush),
    .idex_noop_o       (noop),
    .pipe_freeze_o     (freeze),
    .timeout_err_o     (terr),
    .stall_cnt_o       (stall_cnt),
    .flush_cnt_o       (flush_cnt),
    .freeze_cnt_o      (freeze_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; memread = 1'b0; rd = '0; rs1 = '0; rs2 = '0;
    br = 1'b0; req = 1'b0; ack = 1'b0; clr = 1'b0;
    #3;
    chk("rst_freeze", freeze, 1);
    chk("rst_pcw", pc_w, 0);
    chk("rst_ifidw", ifid_w, 0);
    chk("rst_noop", noop, 0);
    chk("rst_terr", terr, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("idle_pcw", pc_w, 1);
    chk("idle_freeze", freeze, 0);

    // load-use on rs2
    memread = 1'b1; rd = 5'd5; rs2 = 5'd5; rs1 = 5'd0;
    #1;
    chk("lu_pcw", pc_w, 0);
    chk("lu_ifidw", ifid_w, 0);
    chk("lu_noop", noop, 1);
    chk("lu_cnt0", stall_cnt, 0);
    tick();
    chk("lu_cnt1", stall_cnt, 1);
    // x0 destination never stalls
    rd = 5'd0;
    #1;
    chk("x0_noop", noop, 0);
    chk("x0_pcw", pc_w, 1);
    tick();
    chk("x0_cnt", stall_cnt, 1);

    // stall beats branch, then branch alone flushes
    rd = 5'd5; br = 1'b1;
    #1;
    chk("lubr_flush", flush, 0);
    chk("lubr_noop", noop, 1);
    tick();
    chk("lubr_fcnt", flush_cnt, 0);
    memread = 1'b0;
    #1;
    chk("br_flush", flush, 1);
    chk("br_pcw", pc_w, 1);
    chk("br_noop", noop, 0);
    tick();
    chk("br_fcnt", flush_cnt, 1);
    br = 1'b0;

    // clear, then memory wait acked on 4th cycle
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_stall", stall_cnt, 0);
    chk("clr_flush", flush_cnt, 0);
    req = 1'b1;
    #1;
    chk("mw1_freeze", freeze, 1);
    chk("mw1_pcw", pc_w, 0);
    tick();
    memread = 1'b1;
    #1;
    chk("mw2_freeze", freeze, 1);
    chk("mw2_noop", noop, 0);
    tick();
    memread = 1'b0;
    #1;
    chk("mw3_freeze", freeze, 1);
    tick();
    ack = 1'b1;
    #1;
    chk("mw4_freeze", freeze, 0);
    chk("mw4_pcw", pc_w, 1);
    tick();
    chk("mw_fzcnt", freeze_cnt, 3);
    chk("mw_stcnt", stall_cnt, 0);
    #1;
    chk("zw_freeze", freeze, 0);
    tick();
    chk("zw_fzcnt", freeze_cnt, 3);
    req = 1'b0; ack = 1'b0;

    // reset in the middle of WAIT
    req = 1'b1;
    tick();
    chk("rw_fzcnt", freeze_cnt, 1 + 3);
    rst = 1'b1;
    #1;
    chk("rw_freeze", freeze, 1);
    chk("rw_pcw", pc_w, 0);
    chk("rw_fzcnt0", freeze_cnt, 0);
    req = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    chk("rw_idle", freeze, 0);
    chk("rw_idle_pcw", pc_w, 1);

    // timeout after 8 frozen cycles
    req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("to_freeze", freeze, 1);
      chk("to_terr", terr, 0);
      tick();
    end
    chk("to_fault", terr, 1);
    chk("to_freeze_f", freeze, 1);
    chk("to_fzcnt", freeze_cnt, 8);
    ack = 1'b1;
    #1;
    chk("to_ackign", freeze, 1);
    tick();
    chk("to_fzcnt9", freeze_cnt, 9);
    req = 1'b0; ack = 1'b0;
    tick();
    chk("to_sticky", terr, 1);
    chk("to_sticky_fz", freeze, 1);
    rst = 1'b1;
    #1;
    chk("to_rst_terr", terr, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("to_rst_idle", freeze, 0);

    // saturation and clear while stalling
    memread = 1'b1; rd = 5'd7; rs1 = 5'd7; rs2 = 5'd1;
    repeat (20) tick();
    chk("sat_stall", stall_cnt, 15);
    clr = 1'b1;
    tick();
    chk("clr_wins", stall_cnt, 0);
    clr = 1'b0;
    tick();
    chk("post_clr", stall_cnt, 1);
    memread = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
